bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single req/gnt/data bus slave port among NUM_REQ master-side requesters. Each requester drives req and data and receives a one-hot gnt. The owner's req and data are forwarded to the slave side, and a transfer is counted whenever the slave returns gnt. Ownership is held while the owner keeps req high, is preempted after MAX_HOLD accepted transfers if others are waiting, and every ownership change inserts one dead turnaround cycle.

---
 rtl/bus_rr_arbiter.sv | 118 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/data slave port among NUM_REQ requesters.
// Ownership holds while req stays high, yields after MAX_HOLD transfers if others wait, and every handover costs one dead cycle.
module bus_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] m_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      s_req,
  output logic [DATA_W-1:0]         s_data,
  input  logic                      s_gnt,
  output logic [OW-1:0]             owner,
  output logic                      busy
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [OW-1:0]      owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [CW-1:0]      xfer_cnt, cnt_d;

  logic               win_vld;
  logic [OW-1:0]      win_idx;
  logic               others_wait;
  logic               at_limit;

  // Rotating scan: last+1 first, the previous owner is considered last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && req[OW'((32'(last_q) + k) % NUM_REQ)]) begin
        win_vld = 1'b1;
        win_idx = OW'((32'(last_q) + k) % NUM_REQ);
      end
    end
  end

  assign others_wait = |(req & ~gnt);
  assign at_limit    = (xfer_cnt == CW'(MAX_HOLD));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      last_q   <= OW'(NUM_REQ - 1);
      xfer_cnt <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      last_q   <= last_d;
      xfer_cnt <= cnt_d;
    end
  end

  // Next-state logic; a release takes priority over a preempt but both end the same way.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    owner_d = owner;
    last_d  = last_q;
    cnt_d   = xfer_cnt;
    case (state_q)
      IDLE, TURN: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[owner] || (at_limit && others_wait)) begin
          state_d = TURN;
          gnt_d   = '0;
          last_d  = owner;
        end else if (s_gnt && !at_limit) begin
          cnt_d = xfer_cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Slave-side forwarding, gated by the registered state.
  always_comb begin
    busy   = (state_q == GRANT);
    s_req  = 1'b0;
    s_data = '0;
    if (state_q == GRANT) begin
      s_req  = req[owner];
      s_data = m_data[32'(owner) * DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=4).
// Vectors are applied before a rising edge and outputs sampled 1 time unit after it.
module tb_bus_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] m_data;
  logic [3:0]  gnt;
  logic        s_req;
  logic [7:0]  s_data;
  logic        s_gnt;
  logic [1:0]  owner;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic       sg;
    logic [3:0] egnt;
    logic [1:0] eown;
    logic       ebusy;
    logic       esreq;
    logic [7:0] esd;
  } vec_t;

  vec_t tbl[$];

  bus_rr_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .m_data(m_data),
    .gnt   (gnt),
    .s_req (s_req),
    .s_data(s_data),
    .s_gnt (s_gnt),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                         input logic eb, input logic es, input logic [7:0] ed);
    check({tag, ".gnt"},    32'(gnt),    32'(eg));
    check({tag, ".owner"},  32'(owner),  32'(eo));
    check({tag, ".busy"},   32'(busy),   32'(eb));
    check({tag, ".s_req"},  32'(s_req),  32'(es));
    check({tag, ".s_data"}, 32'(s_data), 32'(ed));
  endtask

  task automatic step(input logic [3:0] r, input logic sg);
    req   = r;
    s_gnt = sg;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [3:0] r, input logic sg, input logic [3:0] eg,
                              input logic [1:0] eo, input logic eb, input logic es,
                              input logic [7:0] ed);
    vec_t v;
    v.req = r; v.sg = sg; v.egnt = eg; v.eown = eo;
    v.ebusy = eb; v.esreq = es; v.esd = ed;
    tbl.push_back(v);
  endfunction

  initial begin
    rst_n  = 1'b0;
    req    = 4'b0000;
    s_gnt  = 1'b0;
    m_data = {8'h33, 8'h22, 8'h11, 8'hA5};

    // Idle with nothing requested; a stray s_gnt must be ignored.
    for (int i = 0; i < 5; i++) add(4'b0000, i == 2, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    // Grant to 1 from 1010, release, one TURN cycle, then 3.
    add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h11);
    add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h11);
    add(4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00);
    add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h33);
    add(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h00);
    add(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h00);
    // Preempt of 0 after four accepted transfers while 1 waits.
    add(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) add(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5);
    add(4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    add(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h11);
    add(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00);
    add(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    cmp_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].sg);
      cmp_all($sformatf("vec%0d", i), tbl[i].egnt, tbl[i].eown, tbl[i].ebusy,
              tbl[i].esreq, tbl[i].esd);
    end

    // Sole requester keeps the grant past saturation with no dead cycle.
    step(4'b0100, 1'b1);
    cmp_all("hold0", 4'b0100, 2'd2, 1'b1, 1'b1, 8'h22);
    for (int i = 1; i < 20; i++) begin
      step(4'b0100, 1'b1);
      check($sformatf("hold%0d.gnt", i), 32'(gnt), 32'h4);
    end
    check("hold.xfer_cnt", 32'(dut.xfer_cnt), 32'd4);
    step(4'b1100, 1'b0);
    cmp_all("hold_preempt", 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00);
    step(4'b1100, 1'b0);
    cmp_all("hold_next", 4'b1000, 2'd3, 1'b1, 1'b1, 8'h33);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    cmp_all("hold_idle", 4'b0000, 2'd3, 1'b0, 1'b0, 8'h00);

    // All requesting; each owner drops for one cycle then re-requests: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      logic [1:0] o;
      logic [3:0] oh;
      o  = 2'(i % 4);
      oh = 4'b0001 << o;
      step(4'b1111, 1'b0);
      cmp_all($sformatf("rot%0d", i), oh, o, 1'b1, 1'b1, m_data[32'(o) * 8 +: 8]);
      step(4'b1111 & ~oh, 1'b0);
      cmp_all($sformatf("rot%0d_turn", i), 4'b0000, o, 1'b0, 1'b0, 8'h00);
    end
    step(4'b0000, 1'b0);
    cmp_all("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset while 2 owns the bus.
    step(4'b0100, 1'b0);
    cmp_all("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b1, 8'h22);
    #2 rst_n = 1'b0;
    #1;
    cmp_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 1'b0);
    cmp_all("post_rst", 4'b0100, 2'd2, 1'b1, 1'b1, 8'h22);

    // Second reset: pointer restart gives requester 0 priority over 2.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0101, 1'b0);
    cmp_all("rst_prio", 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
